// File: rtl/pipeline_run_ctrl_if.sv
// Command channel from the debug unit into the run controller.
// Valid/ready handshake carrying an opcode and a step count.
interface pipeline_run_ctrl_if #(
  parameter int NB_STEP = 8
);
  logic               cmd_valid_i;
  logic               cmd_ready_o;
  logic [1:0]         cmd_op_i;
  logic [NB_STEP-1:0] cmd_steps_i;

  modport master (
    output cmd_valid_i,
    output cmd_op_i,
    output cmd_steps_i,
    input  cmd_ready_o
  );

  modport slave (
    input  cmd_valid_i,
    input  cmd_op_i,
    input  cmd_steps_i,
    output cmd_ready_o
  );
endinterface

// File: rtl/pipeline_run_ctrl.sv
// Run/step controller: drives the global pipeline enable from
// debug commands, stops on HALT in write-back, counts run cycles.
module pipeline_run_ctrl #(
  parameter int N_STAGES = 5,
  parameter int NB_CYCLE = 32,
  parameter int NB_STEP  = 8
) (
  input  logic                clock,
  input  logic                reset,
  pipeline_run_ctrl_if.slave  cmd,
  input  logic                load_busy_i,
  input  logic                halt_wb_i,
  output logic                en_pipeline_o,
  output logic [1:0]          state_o,
  output logic [NB_CYCLE-1:0] cycle_count_o,
  output logic [NB_STEP-1:0]  steps_left_o,
  output logic                done_o,
  output logic                cmd_err_o,
  output logic [7:0]          depth_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    STEP   = 2'b10,
    HALTED = 2'b11
  } state_t;

  localparam logic [1:0] OP_RUN   = 2'b00;
  localparam logic [1:0] OP_STEP  = 2'b01;
  localparam logic [1:0] OP_STOP  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  state_t              state, state_n;
  logic [NB_STEP-1:0]  steps, steps_n;
  logic [NB_CYCLE-1:0] cnt, cnt_n;
  logic                done_n, err_n, clr;
  logic                acc, en;
  logic                is_stop;

  assign cmd.cmd_ready_o = reset & ~load_busy_i;
  assign acc     = cmd.cmd_valid_i & cmd.cmd_ready_o;
  assign is_stop = (cmd.cmd_op_i == OP_STOP);
  assign en      = (state == RUN) || (state == STEP);

  always_comb begin
    state_n = state;
    steps_n = steps;
    done_n  = 1'b0;
    err_n   = 1'b0;
    clr     = 1'b0;
    unique case (state)
      IDLE: begin
        if (acc) begin
          unique case (cmd.cmd_op_i)
            OP_RUN:  state_n = RUN;
            OP_STEP: begin
              state_n = STEP;
              steps_n = (cmd.cmd_steps_i == '0) ?
                        NB_STEP'(1) : cmd.cmd_steps_i;
            end
            OP_CLEAR: clr = 1'b1;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (halt_wb_i) begin
          state_n = HALTED;
          done_n  = 1'b1;
        end else if (acc) begin
          if (is_stop) state_n = IDLE;
          else         err_n   = 1'b1;
        end
      end
      STEP: begin
        steps_n = steps - NB_STEP'(1);
        if (halt_wb_i) begin
          state_n = HALTED;
          done_n  = 1'b1;
        end else if (steps == NB_STEP'(1)) begin
          state_n = IDLE;
          done_n  = 1'b1;
          steps_n = '0;
        end else if (acc) begin
          if (is_stop) begin
            state_n = IDLE;
            steps_n = '0;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      HALTED: begin
        if (acc) begin
          unique case (cmd.cmd_op_i)
            OP_CLEAR: begin
              state_n = IDLE;
              clr     = 1'b1;
            end
            OP_STOP: ;
            default: err_n = 1'b1;
          endcase
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Clear only happens when idle/halted, so it never races an increment.
  always_comb begin
    cnt_n = cnt;
    if (clr)
      cnt_n = '0;
    else if (en && (cnt != '1))
      cnt_n = cnt + NB_CYCLE'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      steps     <= '0;
      cnt       <= '0;
      done_o    <= 1'b0;
      cmd_err_o <= 1'b0;
    end else begin
      state     <= state_n;
      steps     <= steps_n;
      cnt       <= cnt_n;
      done_o    <= done_n;
      cmd_err_o <= err_n;
    end
  end

  assign en_pipeline_o = en;
  assign state_o       = state;
  assign cycle_count_o = cnt;
  assign steps_left_o  = steps;
  assign depth_o       = 8'(N_STAGES);

endmodule

// File: doc/pipeline_run_ctrl.md
# pipeline_run_ctrl

Run/step controller for the 5-stage MIPS pipeline. It generates the global pipeline enable from a small command interface driven by the debug UART unit, and supports:

- free-running execution until the HALT instruction reaches write-back,
- N-cycle single-stepping,
- immediate pause,
- a saturating executed-cycle counter.

It sits between the debug unit and the pipeline top. It replaces the hand-driven enable with a parametrised, protocol-checked controller.

## Interface

- N_STAGES, 5, pipeline depth; reported on `depth_o` for host-side drain calculations
- NB_CYCLE, 32, width of the executed-cycle counter
- NB_STEP, 8, width of the step-count field and remaining-step counter

- `clock`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `cmd_valid_i`  in  1  command strobe
- `cmd_ready_o`  out  1  command accepted at a rising edge where `cmd_valid_i & cmd_ready_o`
- `cmd_op_i`  in  2  00 RUN, 01 STEP, 10 STOP, 11 CLEAR
- `cmd_steps_i`  in  NB_STEP  cycle count for STEP; 0 treated as 1
- `load_busy_i`  in  1  instruction loader is writing instruction memory
- `halt_wb_i`  in  1  HALT instruction present in the MEM/WB register
- `en_pipeline_o`  out  1  global pipeline/fetch enable
- `state_o`  out  2  00 IDLE, 01 RUN, 10 STEP, 11 HALTED
- `cycle_count_o`  out  NB_CYCLE  number of cycles with `en_pipeline_o`=1
- `steps_left_o`  out  NB_STEP  remaining STEP cycles
- `done_o`  out  1  one-cycle pulse when RUN or STEP terminates by halt or step exhaustion
- `cmd_err_o`  out  1  one-cycle pulse when an illegal command is accepted
- `depth_o`  out  8  constant N_STAGES

## Operation

- `cmd_ready_o = reset & ~load_busy_i`. This is the only combinational input-to-output path.
- `en_pipeline_o` is decoded from the state register only: it is 1 exactly when the state is RUN or STEP.

State transitions on an accepted command (all others hold):

- **IDLE:**
  - RUN → RUN
  - STEP → STEP, with `steps_left` = max(`cmd_steps_i`, 1)
  - STOP → no-op
  - CLEAR → `cycle_count` = 0
- **RUN:**
  - sampled `halt_wb_i`=1 → HALTED and `done_o` pulse
  - else STOP → IDLE
  - RUN, STEP or CLEAR → `cmd_err_o`, no state change
- **STEP:** each cycle `steps_left` decrements.
  - `halt_wb_i`=1 → HALTED, `done_o`
  - else `steps_left`==1 → IDLE, `done_o`, `steps_left` = 0
  - else STOP → IDLE, `steps_left` = 0
  - RUN, STEP or CLEAR → `cmd_err_o`
- **HALTED:**
  - CLEAR → IDLE and `cycle_count` = 0 (new program)
  - STOP → no-op
  - RUN or STEP → `cmd_err_o`

Priority within one edge: `halt_wb_i` > step exhaustion > accepted command.
- A STOP that coincides with halt or exhaustion is consumed silently, with no error.
- A command is counted as accepted even when it is illegal or ignored.

`cycle_count`:
- increments by 1 on every edge where `en_pipeline_o`=1,
- saturates at 2^NB_CYCLE−1 with no wrap,
- a CLEAR in IDLE or HALTED takes precedence over the increment.

`load_busy_i`:
- blocks command acceptance only;
- does not alter RUN or STEP already in progress.

## Timing

- Command accepted at edge k → new state and `en_pipeline_o` valid from edge k onward. The first enabled pipeline edge is k+1.
- STEP n: `en_pipeline_o` high for exactly n cycles (edges k+1..k+n). `done_o` is high in the cycle after edge k+n, and the state is IDLE from then.
- RUN termination: if `halt_wb_i` is high in an enabled cycle, that cycle's edge is the last enabled edge. `en_pipeline_o` = 0 and `done_o` = 1 in the next cycle.
- STOP at edge k: edge k is still enabled, because the state was RUN or STEP during cycle k. From then `en_pipeline_o` = 0.
- `done_o` and `cmd_err_o` are registered single-cycle pulses.
- Reset values while `reset`=0 (applied asynchronously):
  - `state_o`=IDLE
  - `en_pipeline_o`=0
  - `cycle_count_o`=0
  - `steps_left_o`=0
  - `done_o`=0
  - `cmd_err_o`=0
  - `cmd_ready_o`=0
- Reset asserted mid-RUN or mid-STEP drops `en_pipeline_o` immediately. No pulse is emitted.

## Test plan

- Reset, then STEP with `cmd_steps_i`=3 → `en_pipeline_o` high exactly 3 cycles, `cycle_count_o`=3, one `done_o` pulse, state IDLE, `steps_left_o` 3→2→1→0.
- STEP with `cmd_steps_i`=0 → exactly 1 enabled cycle and `done_o`.
- RUN, then assert `halt_wb_i` in enabled cycle 20 → 20 enabled edges, `cycle_count_o`=20, state HALTED, `done_o` once. A subsequent RUN gives `cmd_err_o` with state unchanged; CLEAR gives IDLE with count 0.
- RUN, STOP at cycle 7, then RUN again with STOP after 5 more cycles → `cycle_count_o`=12 and state IDLE. A same-edge STOP plus `halt_wb_i` gives HALTED with no `cmd_err_o`.
- `load_busy_i`=1 with `cmd_valid_i` held → `cmd_ready_o`=0 and no transition. Drop busy → the command is accepted on the next edge.
- With NB_CYCLE=4, RUN for 20 cycles → `cycle_count_o` saturates at 15. Assert reset mid-STEP → all outputs at reset values immediately.
